// File: rtl/next_inv_j.sv
// next_inv_j: Broyden "good" rank-1 update of a 3x4 fp32 inverse Jacobian, one result per clock.
// Optional define NEXT_INV_J_ZERO_GUARD_EN holds H unchanged when the denominator is zero or NaN.
`default_nettype none

module next_inv_j (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] invJ0,  input logic [31:0] invJ1,  input logic [31:0] invJ2,  input logic [31:0] invJ3,
  input  logic [31:0] invJ4,  input logic [31:0] invJ5,  input logic [31:0] invJ6,  input logic [31:0] invJ7,
  input  logic [31:0] invJ8,  input logic [31:0] invJ9,  input logic [31:0] invJ10, input logic [31:0] invJ11,
  input  logic [31:0] f0,      input logic [31:0] f1,      input logic [31:0] f2,      input logic [31:0] f3,
  input  logic [31:0] next_f0, input logic [31:0] next_f1, input logic [31:0] next_f2, input logic [31:0] next_f3,
  input  logic [31:0] x0,      input logic [31:0] x1,      input logic [31:0] x2,
  input  logic [31:0] next_x0, input logic [31:0] next_x1, input logic [31:0] next_x2,
  output logic [31:0] next_invJ0,  output logic [31:0] next_invJ1,  output logic [31:0] next_invJ2,
  output logic [31:0] next_invJ3,  output logic [31:0] next_invJ4,  output logic [31:0] next_invJ5,
  output logic [31:0] next_invJ6,  output logic [31:0] next_invJ7,  output logic [31:0] next_invJ8,
  output logic [31:0] next_invJ9,  output logic [31:0] next_invJ10, output logic [31:0] next_invJ11
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  endfunction

  // Subnormals have a zero exponent field, so they count as zero everywhere.
  function automatic logic is_zero(input logic [31:0] a);
    return a[30:23] == 8'h00;
  endfunction

  // m carries the hidden bit at m[23]; rounds to nearest-even, then saturates or flushes.
  function automatic logic [31:0] pack(input logic s, input int e, input logic [23:0] m,
                                       input logic g, input logic st);
    logic [24:0] r;
    logic [22:0] frac;
    int          ee;
    r    = {1'b0, m} + 25'(g & (st | m[0]));
    frac = r[24] ? r[23:1] : r[22:0];
    ee   = e + (r[24] ? 1 : 0);
    if (ee >= 255) return {s, 8'hFF, 23'd0};
    if (ee <= 0)   return {s, 31'd0};
    return {s, ee[7:0], frac};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) || is_inf(b)) return (is_zero(a) || is_zero(b)) ? QNAN : {s, 8'hFF, 23'd0};
    if (is_zero(a) || is_zero(b)) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return pack(s, e + 1, p[47:24], p[23], |p[22:0]);
    return pack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [49:0] num;
    logic [49:0] den_m;
    logic [26:0] q;
    logic        rem_nz;
    int          e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_inf(a) && is_inf(b)) || (is_zero(a) && is_zero(b))) return QNAN;
    if (is_inf(a) || is_zero(b)) return {s, 8'hFF, 23'd0};
    if (is_inf(b) || is_zero(a)) return {s, 31'd0};
    num    = {1'b1, a[22:0], 26'd0};
    den_m  = {26'd0, 1'b1, b[22:0]};
    q      = 27'(num / den_m);
    rem_nz = (num % den_m) != 50'd0;
    e      = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[26]) return pack(s, e, q[26:3], q[2], (|q[1:0]) | rem_nz);
    return pack(s, e - 1, q[25:2], q[1], q[0] | rem_nz);
  endfunction

  // Three extra low bits (guard, round, sticky) keep the aligned add exact enough for RNE.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] xb, yb;
    logic [26:0] mx, my, ysh, n, diff;
    logic [27:0] sum;
    logic        st, found;
    int          sh, e, lz;
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) && is_inf(b)) return (a[31] != b[31]) ? QNAN : a;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if (is_zero(a) && is_zero(b)) return {a[31] & b[31], 31'd0};
    if (is_zero(a)) return b;
    if (is_zero(b)) return a;
    if (b[30:0] > a[30:0]) begin xb = b; yb = a; end
    else                   begin xb = a; yb = b; end
    sh = int'(xb[30:23]) - int'(yb[30:23]);
    e  = int'(xb[30:23]);
    mx = {1'b1, xb[22:0], 3'b000};
    my = {1'b1, yb[22:0], 3'b000};
    if (sh >= 27) begin
      ysh = 27'd0;
      st  = 1'b1;
    end else begin
      ysh = my >> sh;
      st  = |(27'(my << (27 - sh)));
    end
    ysh = {ysh[26:1], ysh[0] | st};
    if (xb[31] == yb[31]) begin
      sum = {1'b0, mx} + {1'b0, ysh};
      if (sum[27]) begin
        n = {sum[27:2], sum[1] | sum[0]};
        e = e + 1;
      end else begin
        n = sum[26:0];
      end
    end else begin
      diff = mx - ysh;
      if (diff == 27'd0) return 32'h0000_0000;
      lz    = 0;
      found = 1'b0;
      for (int k = 26; k >= 0; k--) begin
        if (!found && diff[k]) begin
          lz    = 26 - k;
          found = 1'b1;
        end
      end
      n = 27'(diff << lz);
      e = e - lz;
    end
    return pack(xb[31], e, n[26:3], n[2], |n[1:0]);
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    return fadd(a, {~b[31], b[30:0]});
  endfunction

  logic [31:0] h   [12];
  logic [31:0] fv  [4];
  logic [31:0] nf  [4];
  logic [31:0] xv  [3];
  logic [31:0] nx  [3];
  logic [31:0] dx  [3];
  logic [31:0] df  [4];
  logic [31:0] u   [3];
  logic [31:0] v   [4];
  logic [31:0] w   [4];
  logic [31:0] upd [12];
  logic [31:0] acc;
  logic [31:0] den;
  logic        hold;
  logic [31:0] h_q [12];

  assign h[0] = invJ0; assign h[1] = invJ1; assign h[2]  = invJ2;  assign h[3]  = invJ3;
  assign h[4] = invJ4; assign h[5] = invJ5; assign h[6]  = invJ6;  assign h[7]  = invJ7;
  assign h[8] = invJ8; assign h[9] = invJ9; assign h[10] = invJ10; assign h[11] = invJ11;
  assign fv[0] = f0; assign fv[1] = f1; assign fv[2] = f2; assign fv[3] = f3;
  assign nf[0] = next_f0; assign nf[1] = next_f1; assign nf[2] = next_f2; assign nf[3] = next_f3;
  assign xv[0] = x0; assign xv[1] = x1; assign xv[2] = x2;
  assign nx[0] = next_x0; assign nx[1] = next_x1; assign nx[2] = next_x2;

  always_comb begin
    acc = 32'd0;
    den = 32'd0;
    for (int k = 0; k < 3; k++) dx[k] = fsub(nx[k], xv[k]);
    for (int j = 0; j < 4; j++) df[j] = fsub(nf[j], fv[j]);
    // u = dx - H*df, accumulated strictly left to right
    for (int i = 0; i < 3; i++) begin
      acc = fmul(h[4*i], df[0]);
      for (int j = 1; j < 4; j++) acc = fadd(acc, fmul(h[4*i+j], df[j]));
      u[i] = fsub(dx[i], acc);
    end
    for (int j = 0; j < 4; j++)
      v[j] = fadd(fadd(fmul(dx[0], h[j]), fmul(dx[1], h[4+j])), fmul(dx[2], h[8+j]));
    den = fmul(v[0], df[0]);
    for (int j = 1; j < 4; j++) den = fadd(den, fmul(v[j], df[j]));
    for (int j = 0; j < 4; j++) w[j] = fdiv(v[j], den);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++)
        upd[4*i+j] = fadd(h[4*i+j], fmul(u[i], w[j]));
  end

`ifdef NEXT_INV_J_ZERO_GUARD_EN
  assign hold = is_zero(den) || is_nan(den);
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    for (int q = 0; q < 12; q++) begin
      if (rst)       h_q[q] <= 32'h0000_0000;
      else if (hold) h_q[q] <= h[q];
      else           h_q[q] <= upd[q];
    end
  end

  assign next_invJ0 = h_q[0]; assign next_invJ1 = h_q[1]; assign next_invJ2  = h_q[2];  assign next_invJ3  = h_q[3];
  assign next_invJ4 = h_q[4]; assign next_invJ5 = h_q[5]; assign next_invJ6  = h_q[6];  assign next_invJ7  = h_q[7];
  assign next_invJ8 = h_q[8]; assign next_invJ9 = h_q[9]; assign next_invJ10 = h_q[10]; assign next_invJ11 = h_q[11];

endmodule

`default_nettype wire

// File: tb/tb_next_inv_j.sv
// tb_next_inv_j: directed vectors with hand-computed fp32 results for next_inv_j.
`default_nettype none

module tb_next_inv_j;

  localparam logic [31:0] ZERO  = 32'h0000_0000;
  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;
  localparam logic [31:0] FOUR  = 32'h4080_0000;
  localparam logic [31:0] QTR   = 32'h3E80_0000;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] h  [12];
  logic [31:0] f  [4];
  logic [31:0] nf [4];
  logic [31:0] x  [3];
  logic [31:0] nx [3];
  logic [31:0] o  [12];
  logic [31:0] exp_w [12];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  next_inv_j dut (
    .clk(clk), .rst(rst),
    .invJ0(h[0]), .invJ1(h[1]), .invJ2(h[2]),  .invJ3(h[3]),  .invJ4(h[4]),   .invJ5(h[5]),
    .invJ6(h[6]), .invJ7(h[7]), .invJ8(h[8]),  .invJ9(h[9]),  .invJ10(h[10]), .invJ11(h[11]),
    .f0(f[0]), .f1(f[1]), .f2(f[2]), .f3(f[3]),
    .next_f0(nf[0]), .next_f1(nf[1]), .next_f2(nf[2]), .next_f3(nf[3]),
    .x0(x[0]), .x1(x[1]), .x2(x[2]),
    .next_x0(nx[0]), .next_x1(nx[1]), .next_x2(nx[2]),
    .next_invJ0(o[0]), .next_invJ1(o[1]), .next_invJ2(o[2]),  .next_invJ3(o[3]),
    .next_invJ4(o[4]), .next_invJ5(o[5]), .next_invJ6(o[6]),  .next_invJ7(o[7]),
    .next_invJ8(o[8]), .next_invJ9(o[9]), .next_invJ10(o[10]), .next_invJ11(o[11])
  );

  task automatic set_case2();
    for (int q = 0; q < 12; q++) h[q] = (q < 4) ? ONE : (q < 8) ? TWO : THREE;
    f[0] = ONE; f[1] = TWO;   f[2] = THREE; f[3] = ONE;
    nf[0] = TWO; nf[1] = THREE; nf[2] = FOUR; nf[3] = TWO;
    for (int k = 0; k < 3; k++) begin x[k] = ONE; nx[k] = TWO; end
  endtask

  task automatic set_case3();
    for (int q = 0; q < 12; q++) h[q] = ZERO;
    h[0] = ONE; h[5] = ONE; h[10] = ONE;
    for (int j = 0; j < 4; j++) begin f[j] = ZERO; nf[j] = ZERO; end
    for (int k = 0; k < 3; k++) begin x[k] = ZERO; nx[k] = ZERO; end
    nf[0] = ONE; nx[0] = TWO;
  endtask

  task automatic exp_fill(input logic [31:0] val);
    for (int q = 0; q < 12; q++) exp_w[q] = val;
  endtask

  task automatic exp_case2();
    exp_fill(QTR);
  endtask

  task automatic exp_case3();
    exp_fill(ZERO);
    exp_w[0] = TWO; exp_w[5] = ONE; exp_w[10] = ONE;
  endtask

  task automatic exp_inputs();
    for (int q = 0; q < 12; q++) exp_w[q] = h[q];
  endtask

  // Inputs are applied at a falling edge; one rising edge later the result is sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag);
    for (int q = 0; q < 12; q++) begin
      n_tests++;
      assert (o[q] === exp_w[q])
      else begin
        n_fail++;
        $error("FAIL %s word%0d observed=%h expected=%h", tag, q, o[q], exp_w[q]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_case2();
    @(negedge clk);
    step();
    exp_fill(ZERO); check("reset_edge1");
    step();
    check("reset_edge2");

    rst = 1'b0;
    set_case2();
    step();
    exp_case2(); check("rows_1_2_3");

    set_case3();
    step();
    exp_case3(); check("identity_step");

    // 1 - 2*(1/3): exercises division rounding and cancellation
    set_case3();
    nf[0] = THREE; nx[0] = ONE;
    step();
    exp_fill(ZERO);
    exp_w[0] = 32'h3EAA_AAAA; exp_w[5] = ONE; exp_w[10] = ONE;
    check("one_third");

    set_case3();
    rst = 1'b1;
    step();
    exp_fill(ZERO); check("reset_midstream");
    rst = 1'b0;

    set_case2();
    for (int k = 0; k < 3; k++) nx[k] = x[k];
    step();
`ifdef NEXT_INV_J_ZERO_GUARD_EN
    exp_inputs();
`else
    exp_fill(QNAN);
`endif
    check("zero_denominator");

    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) set_case2(); else set_case3();
      step();
      if (c % 2 == 0) exp_case2(); else exp_case3();
      check(c % 2 == 0 ? "stream_case2" : "stream_case3");
    end

    set_case2();
    h[0] = QNAN;
    step();
`ifdef NEXT_INV_J_ZERO_GUARD_EN
    exp_inputs();
`else
    exp_fill(QNAN);
`endif
    check("nan_input");

    set_case3();
    f[0] = 32'h0000_0005;
    h[1] = 32'h0040_0000;
    step();
    exp_case3(); check("subnormal_input");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
